// File: rtl/synth_pkg.sv
// Shared synth-pipeline definitions: sine table geometry and the loader state encoding.
// The waveform stage declares its table RAM from the same width constants.
package synth_pkg;

    localparam int SINE_TABLE_ADDR_WIDTH = 14;
    localparam int SINE_TABLE_DATA_WIDTH = 15;
    localparam int SINE_TABLE_DEPTH      = 1 << SINE_TABLE_ADDR_WIDTH;

    typedef enum logic [2:0] {
        LOADER_IDLE,
        LOADER_DRAIN,
        LOADER_LOAD,
        LOADER_FINISH,
        LOADER_READY
    } loader_state_e;

endpackage

// File: rtl/sine_table_loader.sv
// Boot/reload controller for the quarter-wave sine table.
// Streams host words into the table RAM write port and keeps the operator
// pipeline gated off while the table is invalid or being rewritten.
// Optional build macro: SINE_LOADER_CHECKSUM_EN adds a 16-bit running sum of
// the words accepted in the current load on o_Checksum (tied to 0 otherwise).
module sine_table_loader
    import synth_pkg::*;
#(
    parameter int ADDR_WIDTH  = SINE_TABLE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SINE_TABLE_DATA_WIDTH,
    parameter int TABLE_DEPTH = SINE_TABLE_DEPTH
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_LoadStart,
    input  logic                  i_WriteValid,
    output logic                  o_WriteReady,
    input  logic [DATA_WIDTH-1:0] i_WriteData,
    input  logic                  i_PipelineIdle,
    output logic                  o_TableWriteEnable,
    output logic [ADDR_WIDTH-1:0] o_TableWriteAddress,
    output logic [DATA_WIDTH-1:0] o_TableWriteData,
    output logic                  o_TableReady,
    output logic                  o_PipelineEnable,
    output logic                  o_Busy,
    output logic [15:0]           o_Checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_DEPTH - 1);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  table_ready_q, table_ready_d;
    logic                  pipe_en_q, pipe_en_d;
    logic                  busy_q, busy_d;
    logic                  handshake;
    logic                  drain_exit;

    // Ready is the only combinational output so a word can be taken every LOAD cycle.
    assign o_WriteReady = (state_q == LOADER_LOAD);
    assign handshake    = i_WriteValid && o_WriteReady;
    assign drain_exit   = (state_q == LOADER_DRAIN) && i_PipelineIdle;

    // Next-state, write-port and status decode; status flags follow the next state
    // so they are valid in the very first cycle of each state.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            LOADER_IDLE: begin
                if (i_LoadStart) state_d = LOADER_DRAIN;
            end
            LOADER_DRAIN: begin
                if (i_PipelineIdle) begin
                    state_d = LOADER_LOAD;
                    count_d = '0;
                end
            end
            LOADER_LOAD: begin
                if (handshake) begin
                    we_d    = 1'b1;
                    waddr_d = count_q;
                    wdata_d = i_WriteData;
                    count_d = count_q + ADDR_WIDTH'(1);  // wraps to 0 after the last word
                    if (count_q == LAST_ADDR) state_d = LOADER_FINISH;
                end
            end
            LOADER_FINISH: begin
                state_d = LOADER_READY;
            end
            LOADER_READY: begin
                if (i_LoadStart) state_d = LOADER_DRAIN;
            end
            default: begin
                state_d = LOADER_IDLE;
            end
        endcase

        table_ready_d = (state_d == LOADER_READY);
        pipe_en_d     = (state_d == LOADER_READY);
        busy_d        = (state_d == LOADER_DRAIN) || (state_d == LOADER_LOAD) ||
                        (state_d == LOADER_FINISH);
    end

    // State, counter and registered outputs; reset abandons any load in progress.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_Reset) begin
            state_q       <= LOADER_IDLE;
            count_q       <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            table_ready_q <= 1'b0;
            pipe_en_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            table_ready_q <= table_ready_d;
            pipe_en_q     <= pipe_en_d;
            busy_q        <= busy_d;
        end
    end

    assign o_TableWriteEnable  = we_q;
    assign o_TableWriteAddress = waddr_q;
    assign o_TableWriteData    = wdata_q;
    assign o_TableReady        = table_ready_q;
    assign o_PipelineEnable    = pipe_en_q;
    assign o_Busy              = busy_q;

`ifdef SINE_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Running modulo-2^16 sum of accepted words; cleared as the load begins, held afterwards.
    always_comb begin
        checksum_d = checksum_q;
        if (drain_exit) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q + 16'(i_WriteData);
        end
    end

    // Checksum register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign o_Checksum = checksum_q;
`else
    logic unused_drain_exit;
    assign unused_drain_exit = drain_exit;
    assign o_Checksum        = 16'd0;
`endif

endmodule

// File: tb/tb_sine_table_loader.sv
// Self-checking bench for sine_table_loader.
// A driver issues loads with randomized host traffic and pushes each word it
// expects to see on the table write port into a queue; a monitor pops and
// compares whenever the write strobe is observed.
module tb_sine_table_loader;

    localparam int AW    = 14;
    localparam int DW    = 15;
    localparam int DEPTH = 1 << AW;

    logic          i_Clock;
    logic          i_Reset;
    logic          i_LoadStart;
    logic          i_WriteValid;
    logic          o_WriteReady;
    logic [DW-1:0] i_WriteData;
    logic          i_PipelineIdle;
    logic          o_TableWriteEnable;
    logic [AW-1:0] o_TableWriteAddress;
    logic [DW-1:0] o_TableWriteData;
    logic          o_TableReady;
    logic          o_PipelineEnable;
    logic          o_Busy;
    logic [15:0]   o_Checksum;

    sine_table_loader dut (
        .i_Clock             (i_Clock),
        .i_Reset             (i_Reset),
        .i_LoadStart         (i_LoadStart),
        .i_WriteValid        (i_WriteValid),
        .o_WriteReady        (o_WriteReady),
        .i_WriteData         (i_WriteData),
        .i_PipelineIdle      (i_PipelineIdle),
        .o_TableWriteEnable  (o_TableWriteEnable),
        .o_TableWriteAddress (o_TableWriteAddress),
        .o_TableWriteData    (o_TableWriteData),
        .o_TableReady        (o_TableReady),
        .o_PipelineEnable    (o_PipelineEnable),
        .o_Busy              (o_Busy),
        .o_Checksum          (o_Checksum)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [15:0]   csum;
    } exp_t;

    exp_t        exp_q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          strobes = 0;
    logic [15:0] last_sum = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
            if (errors >= 20) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    function automatic logic [15:0] exp_csum(input logic [15:0] s);
`ifdef SINE_LOADER_CHECKSUM_EN
        return s;
`else
        return (s & 16'd0);
`endif
    endfunction

    // Monitor: every observed table write must match the oldest expected word.
    always @(posedge i_Clock) begin
        #1;
        if (o_TableWriteEnable === 1'b1) begin
            strobes++;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(o_TableWriteAddress), 32'(e.addr));
                check("write_data", 32'(o_TableWriteData), 32'(e.data));
                check("checksum_running", 32'(o_Checksum), 32'(exp_csum(e.csum)));
            end
        end
    end

    // Watchdog so a broken run still ends with its summary line.
    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},     32'(o_TableWriteEnable),  32'd0);
        check({tag, "_addr"},   32'(o_TableWriteAddress), 32'd0);
        check({tag, "_data"},   32'(o_TableWriteData),    32'd0);
        check({tag, "_tready"}, 32'(o_TableReady),        32'd0);
        check({tag, "_pen"},    32'(o_PipelineEnable),    32'd0);
        check({tag, "_busy"},   32'(o_Busy),              32'd0);
        check({tag, "_wready"}, 32'(o_WriteReady),        32'd0);
        check({tag, "_csum"},   32'(o_Checksum),          32'd0);
    endtask

    // One table load. data_mode: 0 = addr+1, 1 = random, 2 = all 0x7FFF.
    // pulse_at / abort_at: word count at which to pulse i_LoadStart / assert reset (-1 = never).
    task automatic run_load(input int valid_pct, input int data_mode, input int idle_delay,
                            input int pulse_at, input int abort_at);
        int          accepted = 0;
        bit          pulsed   = 0;
        logic [15:0] sum      = 16'd0;
        logic [DW-1:0] w;

        strobes = 0;
        // Request; a host word is offered already to show it is refused outside LOAD.
        i_LoadStart    = 1'b1;
        i_PipelineIdle = 1'b0;
        i_WriteValid   = 1'b1;
        i_WriteData    = DW'($urandom);
        @(negedge i_Clock);
        i_LoadStart = 1'b0;
        check("drain_tready",  32'(o_TableReady),     32'd0);
        check("drain_pen",     32'(o_PipelineEnable), 32'd0);
        check("drain_busy",    32'(o_Busy),           32'd1);
        check("drain_wready",  32'(o_WriteReady),     32'd0);
        check("drain_csum",    32'(o_Checksum),       32'(exp_csum(last_sum)));
        for (int i = 0; i < idle_delay; i++) begin
            @(negedge i_Clock);
            check("drain_wait_wready", 32'(o_WriteReady), 32'd0);
            check("drain_wait_busy",   32'(o_Busy),       32'd1);
        end
        i_PipelineIdle = 1'b1;
        @(negedge i_Clock);

        while (accepted < DEPTH) begin
            check("load_wready", 32'(o_WriteReady),     32'd1);
            check("load_busy",   32'(o_Busy),           32'd1);
            check("load_pen",    32'(o_PipelineEnable), 32'd0);
            if (accepted == abort_at) begin
                i_WriteValid = 1'b0;
                i_Reset      = 1'b1;
                #1;
                check_all_zero("abort");
                check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
                check("abort_strobes",     32'(strobes),      32'(abort_at));
                @(negedge i_Clock);
                i_Reset  = 1'b0;
                last_sum = 16'd0;
                return;
            end
            if (!pulsed && accepted == pulse_at) begin
                i_LoadStart = 1'b1;
                pulsed      = 1;
            end
            case (data_mode)
                0:       w = DW'(accepted + 1);
                1:       w = DW'($urandom);
                default: w = DW'(15'h7FFF);
            endcase
            i_WriteData  = w;
            i_WriteValid = ($urandom_range(0, 99) < valid_pct);
            if (i_WriteValid) begin
                exp_t e;
                sum    = sum + 16'(w);
                e.addr = AW'(accepted);
                e.data = w;
                e.csum = sum;
                exp_q.push_back(e);
                accepted++;
            end
            @(negedge i_Clock);
            i_LoadStart = 1'b0;
        end

        // One cycle after the last handshake: final write on the port, not ready yet.
        i_WriteValid = 1'b1;
        i_WriteData  = DW'($urandom);
        check("finish_wready", 32'(o_WriteReady), 32'd0);
        check("finish_tready", 32'(o_TableReady), 32'd0);
        check("finish_busy",   32'(o_Busy),       32'd1);
        @(negedge i_Clock);
        // Two cycles after the last handshake: table ready.
        check("ready_tready",  32'(o_TableReady),     32'd1);
        check("ready_pen",     32'(o_PipelineEnable), 32'd1);
        check("ready_busy",    32'(o_Busy),           32'd0);
        check("ready_wready",  32'(o_WriteReady),     32'd0);
        check("ready_csum",    32'(o_Checksum),       32'(exp_csum(sum)));
        check("ready_strobes", 32'(strobes),          32'(DEPTH));
        check("ready_queue",   32'(exp_q.size()),     32'd0);
        @(negedge i_Clock);
        check("ready_hold_tready", 32'(o_TableReady), 32'd1);
        check("ready_hold_csum",   32'(o_Checksum),   32'(exp_csum(sum)));
        i_WriteValid = 1'b0;
        last_sum     = sum;
    endtask

    initial begin
        i_Reset        = 1'b1;
        i_LoadStart    = 1'b0;
        i_WriteValid   = 1'b0;
        i_WriteData    = '0;
        i_PipelineIdle = 1'b0;
        repeat (2) @(negedge i_Clock);
        check_all_zero("reset");
        i_Reset = 1'b0;
        repeat (2) @(negedge i_Clock);
        check_all_zero("idle");

        // Back-to-back addr+1 words from IDLE; a stray load request at word 500.
        run_load(100, 0, 0, 500, -1);
        // Reload from READY with the pipeline busy for 5 cycles and a bursty host.
        run_load(75, 1, 5, -1, -1);
        // Reload abandoned by reset after 100 words.
        run_load(90, 1, 2, -1, 100);
        @(negedge i_Clock);
        check_all_zero("post_abort");
        // Fresh load after reset restarts at address 0; full-scale words.
        run_load(100, 2, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
